// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                           |
// | Purpose  : Shared types, defaults and helpers for the two-way    |
// |            fetch/data memory bus arbiter.                        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  // The requester that is not o
  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

  // Grant state that hands the bus to requester o
  function automatic arb_state_t owner_state(input arb_owner_t o);
    return (o == OWN_IF) ? ARB_IF : ARB_D;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_arb_watchdog                                      |
// | Purpose  : Counts cycles a grant has waited for mem_ready and    |
// |            flags expiry once TIMEOUT_CYCLES have elapsed.        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,   // arbiter is in a grant state
  input  logic clear,    // current transfer completes this cycle
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Count completed waiting cycles of the current grant; restart on every new transfer
  always_ff @(posedge clk) begin
    if (reset || clear || !active) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expired = active && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_bus_arbiter                                       |
// | Purpose  : Round-robin arbiter sharing one native memory bus     |
// |            between instruction fetch and load/store requesters.  |
// |            Grant is held until mem_ready completes the transfer. |
// | Config   : MEM_ARB_TIMEOUT_EN enables the grant watchdog that    |
// |            terminates a stalled transfer with bus_err.           |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_ready,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_valid,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_wstrb,
  output logic              d_ready,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              bus_err
);

  arb_state_t state;
  arb_owner_t last_grant;

  arb_owner_t cur_owner;
  arb_owner_t other;
  logic       own_valid;
  logic       other_valid;
  logic       if_owner;
  logic       d_owner;
  logic       wd_expired;
  logic       timeout_hit;
  logic       xfer_done;

  assign if_owner    = (state == ARB_IF);
  assign d_owner     = (state == ARB_D);
  assign cur_owner   = d_owner ? OWN_D : OWN_IF;
  assign other       = other_owner(cur_owner);
  assign own_valid   = (cur_owner == OWN_IF) ? if_valid : d_valid;
  assign other_valid = (cur_owner == OWN_IF) ? d_valid : if_valid;

  // Memory response wins over a watchdog expiry in the same cycle
  assign timeout_hit = wd_expired && !mem_ready;
  assign xfer_done   = (state != ARB_IDLE) && (mem_ready || wd_expired);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (state != ARB_IDLE),
    .clear   (xfer_done),
    .expired (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
`endif

  // Grant FSM: one-cycle arbitration from idle, back-to-back handoff on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= OWN_D;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_valid && d_valid) begin
            state      <= owner_state(other_owner(last_grant));
            last_grant <= other_owner(last_grant);
          end else if (if_valid) begin
            state      <= ARB_IF;
            last_grant <= OWN_IF;
          end else if (d_valid) begin
            state      <= ARB_D;
            last_grant <= OWN_D;
          end
        end
        ARB_IF, ARB_D: begin
          if (xfer_done) begin
            if (other_valid) begin
              state      <= owner_state(other);
              last_grant <= other;
            end else if (own_valid) begin
              state      <= owner_state(cur_owner);
              last_grant <= cur_owner;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_valid = (state != ARB_IDLE);
  assign mem_instr = if_owner;
  assign mem_addr  = if_owner ? if_addr : (d_owner ? d_addr : '0);
  assign mem_wdata = d_owner ? d_wdata : '0;
  assign mem_wstrb = d_owner ? d_wstrb : '0;

  // A reset cycle never reports completion, even if memory answers
  assign if_ready = !reset && if_owner && xfer_done;
  assign d_ready  = !reset && d_owner && xfer_done;
  assign if_rdata = (if_owner && !timeout_hit) ? mem_rdata : '0;
  assign d_rdata  = (d_owner && !timeout_hit) ? mem_rdata : '0;
  assign bus_err  = !reset && timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_mem_bus_arbiter                                    |
// | Purpose  : Self-checking bench for mem_bus_arbiter: directed      |
// |            scenarios followed by randomized traffic against a    |
// |            cycle-level behavioural model of the arbitration.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  localparam int XLEN = 32;
  localparam int SW   = XLEN / 8;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_valid;
  logic [XLEN-1:0] if_addr;
  logic            if_ready;
  logic [XLEN-1:0] if_rdata;
  logic            d_valid;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [SW-1:0]   d_wstrb;
  logic            d_ready;
  logic [XLEN-1:0] d_rdata;
  logic            mem_valid;
  logic            mem_instr;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [SW-1:0]   mem_wstrb;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  logic            bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .XLEN           (XLEN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_valid   (d_valid),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who holds the bus (0 nobody, 1 fetch, 2 data),
  // who was granted last, and how many cycles the holder has waited.
  int m_own  = 0;
  int m_last = 2;
  int m_wait = 0;

  logic            e_done, e_to;
  logic            e_mem_valid, e_mem_instr, e_if_ready, e_d_ready, e_bus_err;
  logic [XLEN-1:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
  logic [SW-1:0]   e_mem_wstrb;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic req_valid(input int who);
    return (who == 1) ? if_valid : d_valid;
  endfunction

  // Expected bus and requester outputs for the current cycle's inputs
  task automatic model_outputs();
    logic expiry;
`ifdef MEM_ARB_TIMEOUT_EN
    expiry = (m_own != 0) && (m_wait >= TO);
`else
    expiry = 1'b0;
`endif
    e_to        = expiry && !mem_ready;
    e_done      = (m_own != 0) && (mem_ready || expiry);
    e_mem_valid = (m_own != 0);
    e_mem_instr = (m_own == 1);
    e_mem_addr  = (m_own == 1) ? if_addr : ((m_own == 2) ? d_addr : '0);
    e_mem_wdata = (m_own == 2) ? d_wdata : '0;
    e_mem_wstrb = (m_own == 2) ? d_wstrb : '0;
    e_if_ready  = !reset && (m_own == 1) && e_done;
    e_d_ready   = !reset && (m_own == 2) && e_done;
    e_if_rdata  = ((m_own == 1) && !e_to) ? mem_rdata : '0;
    e_d_rdata   = ((m_own == 2) && !e_to) ? mem_rdata : '0;
    e_bus_err   = !reset && e_to;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    int pick;
    pick = 0;
    if (reset) begin
      m_own  = 0;
      m_last = 2;
      m_wait = 0;
    end else if (m_own == 0 || e_done) begin
      if (m_own == 0) begin
        if (if_valid && d_valid) pick = 3 - m_last;
        else if (if_valid)       pick = 1;
        else if (d_valid)        pick = 2;
      end else begin
        if (req_valid(3 - m_own)) pick = 3 - m_own;
        else if (req_valid(m_own)) pick = m_own;
      end
      m_own  = pick;
      if (pick != 0) m_last = pick;
      m_wait = 0;
    end else begin
      m_wait++;
    end
  endtask

  // Inputs are driven 1 time unit after the edge; outputs are checked 3 later
  task automatic check_all();
    #3;
    model_outputs();
    chk("mem_valid", 32'(mem_valid), 32'(e_mem_valid));
    chk("mem_instr", 32'(mem_instr), 32'(e_mem_instr));
    chk("mem_addr",  mem_addr,       e_mem_addr);
    chk("mem_wdata", mem_wdata,      e_mem_wdata);
    chk("mem_wstrb", 32'(mem_wstrb), 32'(e_mem_wstrb));
    chk("if_ready",  32'(if_ready),  32'(e_if_ready));
    chk("if_rdata",  if_rdata,       e_if_rdata);
    chk("d_ready",   32'(d_ready),   32'(e_d_ready));
    chk("d_rdata",   d_rdata,        e_d_rdata);
    chk("bus_err",   32'(bus_err),   32'(e_bus_err));
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    check_all();
    advance();
    reset = 1'b0;
  endtask

  logic got_if, got_d;

  initial begin
    reset     = 1'b1;
    if_valid  = 1'b0;
    if_addr   = '0;
    d_valid   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_wstrb   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    advance();
    advance();
    reset = 1'b0;

    // Reset state
    check_all();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_ready", 32'({if_ready, d_ready, bus_err}), 32'd0);
    advance();

    // Single fetch, memory answers two cycles after grant
    if_valid = 1'b1;
    if_addr  = 32'h0000_0100;
    check_all();
    chk("t1_req_cycle_valid", 32'(mem_valid), 32'd0);
    advance();
    check_all();
    chk("t1_grant_valid", 32'(mem_valid), 32'd1);
    chk("t1_grant_instr", 32'(mem_instr), 32'd1);
    chk("t1_grant_addr", mem_addr, 32'h0000_0100);
    advance();
    check_all();
    advance();
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0013;
    check_all();
    chk("t1_if_ready", 32'(if_ready), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h0000_0013);
    advance();
    idle_inputs();
    pulse_reset();

    // Both requesters from idle, memory always ready: strict alternation
    if_valid  = 1'b1;
    if_addr   = 32'h0000_1000;
    d_valid   = 1'b1;
    d_addr    = 32'h0000_3000;
    d_wstrb   = '0;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    check_all();
    advance();
    for (int k = 0; k < 4; k++) begin
      check_all();
      chk("t2_no_idle_gap", 32'(mem_valid), 32'd1);
      chk("t2_alternate", 32'(mem_instr), ((k % 2) == 0) ? 32'd1 : 32'd0);
      got_if = e_if_ready;
      got_d  = e_d_ready;
      advance();
      if (got_if) if_addr = if_addr + 32'd4;
      if (got_d)  d_addr  = d_addr + 32'd4;
    end
    idle_inputs();
    pulse_reset();

    // Store: strobes and data reach the bus, fetch side stays quiet
    d_valid = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'b0011;
    check_all();
    advance();
    check_all();
    chk("t3_wstrb", 32'(mem_wstrb), 32'h3);
    chk("t3_instr", 32'(mem_instr), 32'd0);
    chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    advance();
    mem_ready = 1'b1;
    check_all();
    chk("t3_d_ready", 32'(d_ready), 32'd1);
    chk("t3_no_if_ready", 32'(if_ready), 32'd0);
    advance();
    idle_inputs();
    pulse_reset();

    // Reset while a load waits on memory; late mem_ready is ignored
    d_valid = 1'b1;
    d_addr  = 32'h0000_0400;
    d_wstrb = '0;
    check_all();
    advance();
    check_all();
    advance();
    reset = 1'b1;
    check_all();
    chk("t4_rst_no_ready", 32'(d_ready), 32'd0);
    advance();
    reset     = 1'b0;
    d_valid   = 1'b0;
    mem_ready = 1'b1;
    check_all();
    chk("t4_after_rst_valid", 32'(mem_valid), 32'd0);
    chk("t4_after_rst_ready", 32'(d_ready), 32'd0);
    advance();

    // mem_ready while idle with no requests
    for (int k = 0; k < 3; k++) begin
      check_all();
      chk("t6_idle_no_ready", 32'({if_ready, d_ready}), 32'd0);
      chk("t6_idle_valid", 32'(mem_valid), 32'd0);
      advance();
    end
    idle_inputs();

`ifdef MEM_ARB_TIMEOUT_EN
    // Stalled data transfer times out, pending fetch takes over
    pulse_reset();
    d_valid   = 1'b1;
    d_addr    = 32'h0000_0500;
    mem_rdata = 32'hFFFF_FFFF;
    check_all();
    advance();
    if_valid = 1'b1;
    if_addr  = 32'h0000_0600;
    for (int k = 0; k < TO; k++) begin
      check_all();
      chk("t5_waiting", 32'({d_ready, bus_err}), 32'd0);
      advance();
    end
    check_all();
    chk("t5_d_ready", 32'(d_ready), 32'd1);
    chk("t5_bus_err", 32'(bus_err), 32'd1);
    chk("t5_d_rdata", d_rdata, 32'd0);
    advance();
    d_valid = 1'b0;
    check_all();
    chk("t5_fetch_next", 32'(mem_instr), 32'd1);
    advance();
    idle_inputs();
`endif

    // Randomized traffic; requesters only change after completion or while idle
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      mem_ready = ($urandom_range(3) != 0);
      mem_rdata = $urandom;
      check_all();
      got_if = e_if_ready;
      got_d  = e_d_ready;
      advance();
      if (!if_valid || got_if) begin
        if_valid = ($urandom_range(1) == 1);
        if_addr  = $urandom;
      end
      if (!d_valid || got_d) begin
        d_valid = ($urandom_range(1) == 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wstrb = SW'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
